// File: rtl/opcode_sequencer_if.sv
// Bundle between opcode_sequencer (master, issues Opcode/Key_0) and the host/ControlUnit side
// (slave, loads the program and controls runs).
interface opcode_sequencer_if #(
    parameter int PROG_DEPTH = 16
) ();
    localparam int AW = $clog2(PROG_DEPTH);

    logic          Start;
    logic          Step_Mode;
    logic          Step_Req;
    logic          Prog_We;
    logic [AW-1:0] Prog_Addr;
    logic [3:0]    Prog_Data;
    logic [3:0]    Opcode;
    logic          Key_0;
    logic [AW-1:0] Pc;
    logic          Busy;
    logic          Done;
    logic          Error;

    modport master (
        input  Start, Step_Mode, Step_Req, Prog_We, Prog_Addr, Prog_Data,
        output Opcode, Key_0, Pc, Busy, Done, Error
    );

    modport slave (
        output Start, Step_Mode, Step_Req, Prog_We, Prog_Addr, Prog_Data,
        input  Opcode, Key_0, Pc, Busy, Done, Error
    );
endinterface

// File: rtl/opcode_sequencer.sv
// Plays a small writable program of 4-bit opcodes onto the Key_0/Opcode strobe interface.
// Optional build macro OPSEQ_LOOP_EN: wrap from the last slot back to slot 0 instead of ending.
module opcode_sequencer #(
    parameter int PROG_DEPTH    = 16,
    parameter int STROBE_CYCLES = 4,
    parameter int GAP_CYCLES    = 4
) (
    input logic                Clock,
    input logic                Reset_n,
    opcode_sequencer_if.master bus
);
    localparam int AW      = $clog2(PROG_DEPTH);
    localparam int CNT_MAX = (STROBE_CYCLES > GAP_CYCLES) ? STROBE_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] STROBE_LOAD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] LAST_PC     = AW'(PROG_DEPTH - 1);
    localparam logic [3:0]    OP_HALT     = 4'd15;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        SETUP,
        STROBE,
        GAP,
        ADV
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [3:0]     prog_q [PROG_DEPTH];
    logic [AW-1:0]  pc_q;
    logic [3:0]     opcode_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;
    logic           error_q;
    logic           busy;
    logic           op_halt;
    logic           op_illegal;

    logic           start_run;
    logic           load_op;
    logic           load_strobe;
    logic           load_gap;
    logic           cnt_dec;
    logic           pc_inc;
    logic           pc_clear;
    logic           fire_done;
    logic           fire_error;

    assign busy       = (state_q != IDLE);
    assign op_halt    = (opcode_q == OP_HALT);
    assign op_illegal = (opcode_q >= 4'd12) && !op_halt;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobe and gap share one down-counter; it is only decremented while nonzero.
    always_comb begin
        state_d     = state_q;
        start_run   = 1'b0;
        load_op     = 1'b0;
        load_strobe = 1'b0;
        load_gap    = 1'b0;
        cnt_dec     = 1'b0;
        pc_inc      = 1'b0;
        pc_clear    = 1'b0;
        fire_done   = 1'b0;
        fire_error  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    state_d   = WAIT;
                    start_run = 1'b1;
                    pc_clear  = 1'b1;
                end
            end
            WAIT: begin
                if (!bus.Step_Mode || bus.Step_Req) begin
                    state_d = SETUP;
                    load_op = 1'b1;
                end
            end
            SETUP: begin
                if (op_halt) begin
                    state_d   = IDLE;
                    fire_done = 1'b1;
                end else if (op_illegal) begin
                    state_d    = IDLE;
                    fire_error = 1'b1;
                end else begin
                    state_d     = STROBE;
                    load_strobe = 1'b1;
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d  = GAP;
                    load_gap = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = ADV;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ADV: begin
                if (pc_q == LAST_PC) begin
`ifdef OPSEQ_LOOP_EN
                    state_d  = WAIT;
                    pc_clear = 1'b1;
`else
                    state_d   = IDLE;
                    fire_done = 1'b1;
`endif
                end else begin
                    state_d = WAIT;
                    pc_inc  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            pc_q     <= '0;
            opcode_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            done_q <= fire_done;
            if (pc_clear) begin
                pc_q <= '0;
            end else if (pc_inc) begin
                pc_q <= pc_q + AW'(1);
            end
            if (load_op) begin
                opcode_q <= prog_q[pc_q];
            end
            if (load_strobe) begin
                cnt_q <= STROBE_LOAD;
            end else if (load_gap) begin
                cnt_q <= GAP_LOAD;
            end else if (cnt_dec) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (start_run) begin
                error_q <= 1'b0;
            end else if (fire_error) begin
                error_q <= 1'b1;
            end
        end
    end

    // Program writes are locked out for the whole run so an issued program cannot change underneath.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < PROG_DEPTH; i++) begin
                prog_q[i] <= OP_HALT;
            end
        end else if (bus.Prog_We && !busy && (int'(bus.Prog_Addr) < PROG_DEPTH)) begin
            prog_q[bus.Prog_Addr] <= bus.Prog_Data;
        end
    end

    assign bus.Opcode = opcode_q;
    assign bus.Key_0  = (state_q == STROBE);
    assign bus.Pc     = pc_q;
    assign bus.Busy   = busy;
    assign bus.Done   = done_q;
    assign bus.Error  = error_q;

endmodule
